// File: rtl/bfm_pkg.sv
// ============================================================================
// Module   : bfm_pkg
// Brief    : Shared types and width helpers for the multi-channel switch/LED BFM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bfm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_REQ = 2'd1,
        RD_REQ = 2'd2
    } bfm_state_t;

    // Wide enough for any supported data width; users slice the low strobe bits.
    localparam logic [127:0] STRB_ALL = '1;

    function automatic int ch_w(input int num_ch);
        return $clog2(num_ch);
    endfunction

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bfm_multi_ch_sequencer_if.sv
// ============================================================================
// Module   : bfm_multi_ch_sequencer_if
// Brief    : User-side request port of the AXI-lite bridge (U_* signal group).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bfm_multi_ch_sequencer_if
    import bfm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                          U_WDONE;
    logic                          U_RDONE;
    logic [DATA_W-1:0]             U_RDATA;
    logic                          U_WVALID;
    logic [ADDR_W-1:0]             U_AWADDR;
    logic [DATA_W-1:0]             U_WDATA;
    logic [strb_w(DATA_W)-1:0]     U_STRB;
    logic                          U_RVALID;
    logic [ADDR_W-1:0]             U_ARADDR;
    logic [3:0]                    U_BLEN;

    modport master (
        input  U_WDONE, U_RDONE, U_RDATA,
        output U_WVALID, U_AWADDR, U_WDATA, U_STRB, U_RVALID, U_ARADDR, U_BLEN
    );

    modport slave (
        output U_WDONE, U_RDONE, U_RDATA,
        input  U_WVALID, U_AWADDR, U_WDATA, U_STRB, U_RVALID, U_ARADDR, U_BLEN
    );

endinterface

`default_nettype wire

// File: rtl/bfm_cycle_timer.sv
// ============================================================================
// Module   : bfm_cycle_timer
// Brief    : Down-counter from PERIOD-1 to 0; expire flags the last cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bfm_cycle_timer #(
    parameter int PERIOD = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic load,
    input  wire logic en,
    output logic      expire
);
    localparam int              CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] c_top = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;

    // Expiry while enabled wraps back to the top so periodic use needs no reload.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_cnt <= c_top;
        end else if (en) begin
            r_cnt <= (r_cnt == '0) ? c_top : r_cnt - 1'b1;
        end
    end

    assign expire = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/bfm_multi_ch_sequencer.sv
// ============================================================================
// Module   : bfm_multi_ch_sequencer
// Brief    : Switch/LED bus-functional master with polled reads and change-triggered writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bfm_multi_ch_sequencer
    import bfm_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              SW_W      = 16,
    parameter int              LED_W     = 13,
    parameter int              NUM_CH    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              POLL_CYC  = 64,
    parameter int              TIMEOUT   = 255,
    parameter logic [3:0]      BLEN      = 4'hF,
    localparam int             CH_W      = ch_w(NUM_CH)
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [SW_W-1:0]   sw,
    bfm_multi_ch_sequencer_if.master bus,
    output logic [LED_W-1:0]       led,
    output logic [CH_W-1:0]        rd_ch,
    output logic                   err
);
    localparam int c_strb_w  = strb_w(DATA_W);
    localparam int c_field_w = SW_W - CH_W - 1;

    bfm_state_t r_state, w_state_nxt;

    logic                r_wvalid, r_rvalid, r_err;
    logic [ADDR_W-1:0]   r_awaddr, r_araddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_strb_w-1:0] r_strb;
    logic [3:0]          r_blen;
    logic [LED_W-1:0]    r_led;
    logic [CH_W-1:0]     r_ch, r_rd_ch;
    logic [DATA_W-1:0]   r_shadow [NUM_CH];
    logic [NUM_CH-1:0]   r_shadow_vld;

    logic                w_mode, w_busy, w_tick, w_dirty;
    logic                w_poll_exp, w_wait_exp;
    logic [CH_W-1:0]     w_ch;
    logic [DATA_W-1:0]   w_data;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_start_wr, w_start_rd, w_wr_done, w_rd_done, w_abort;

    assign w_mode  = sw[SW_W-1];
    assign w_ch    = sw[SW_W-2 -: CH_W];
    assign w_data  = DATA_W'(sw[c_field_w-1:0]);
    assign w_addr  = BASE_ADDR + ADDR_W'(w_ch) * ADDR_W'(c_strb_w);
    assign w_dirty = !r_shadow_vld[w_ch] || (r_shadow[w_ch] != w_data);
    assign w_busy  = (r_state != IDLE);
    assign w_tick  = !w_busy && w_poll_exp;

    bfm_cycle_timer #(.PERIOD(POLL_CYC)) u_poll_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (w_busy),
        .en     (!w_busy),
        .expire (w_poll_exp)
    );

    bfm_cycle_timer #(.PERIOD(TIMEOUT)) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (!w_busy),
        .en     (w_busy),
        .expire (w_wait_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Done is tested before the wait timer so a coincident done completes normally.
    always_comb begin
        w_state_nxt = r_state;
        w_start_wr  = 1'b0;
        w_start_rd  = 1'b0;
        w_wr_done   = 1'b0;
        w_rd_done   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    if (!w_mode) begin
                        w_start_rd  = 1'b1;
                        w_state_nxt = RD_REQ;
                    end else if (w_dirty) begin
                        w_start_wr  = 1'b1;
                        w_state_nxt = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (bus.U_WDONE) begin
                    w_wr_done   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_wait_exp) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                if (bus.U_RDONE) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_wait_exp) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wvalid     <= 1'b0;
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
            r_awaddr     <= '0;
            r_araddr     <= '0;
            r_wdata      <= '0;
            r_strb       <= '0;
            r_blen       <= '0;
            r_led        <= '0;
            r_ch         <= '0;
            r_rd_ch      <= '0;
            r_shadow_vld <= '0;
            for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= '0;
        end else begin
            r_strb <= STRB_ALL[c_strb_w-1:0];
            r_blen <= BLEN;
            if (w_start_wr) begin
                r_wvalid <= 1'b1;
                r_awaddr <= w_addr;
                r_wdata  <= w_data;
                r_ch     <= w_ch;
            end
            if (w_start_rd) begin
                r_rvalid <= 1'b1;
                r_araddr <= w_addr;
                r_ch     <= w_ch;
            end
            if (w_wr_done) begin
                r_wvalid             <= 1'b0;
                r_shadow[r_ch]       <= r_wdata;
                r_shadow_vld[r_ch]   <= 1'b1;
            end
            if (w_rd_done) begin
                r_rvalid <= 1'b0;
                r_led    <= bus.U_RDATA[LED_W-1:0];
                r_rd_ch  <= r_ch;
            end
            if (w_abort) begin
                r_wvalid <= 1'b0;
                r_rvalid <= 1'b0;
                r_err    <= 1'b1;
            end
        end
    end

    assign bus.U_WVALID = r_wvalid;
    assign bus.U_AWADDR = r_awaddr;
    assign bus.U_WDATA  = r_wdata;
    assign bus.U_STRB   = r_strb;
    assign bus.U_RVALID = r_rvalid;
    assign bus.U_ARADDR = r_araddr;
    assign bus.U_BLEN   = r_blen;
    assign led          = r_led;
    assign rd_ch        = r_rd_ch;
    assign err          = r_err;

endmodule

`default_nettype wire
